// File: rtl/red_ghost.sv
// Red ghost sprite controller: holds centre position, steps once per frame tick
// and picks a fresh direction from an LFSR whenever the path ahead is blocked.
//
// state | meaning
// IDLE  | parked at start position, waiting for any key press
// CHASE | moving one STEP per frame tick, re-routing on walls and screen edges
module red_ghost #(
  parameter logic [9:0] START_X = 10'd320,
  parameter logic [9:0] START_Y = 10'd200,
  parameter logic [9:0] SIZE    = 10'd6,
  parameter logic [9:0] STEP    = 10'd1,
  parameter logic [9:0] X_MIN   = 10'd0,
  parameter logic [9:0] X_MAX   = 10'd639,
  parameter logic [9:0] Y_MIN   = 10'd0,
  parameter logic [9:0] Y_MAX   = 10'd479
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic [7:0] keycode,
  input  logic       lifeDown,
  input  logic       restart,
  input  logic [4:0] mapL,
  input  logic [4:0] mapR,
  input  logic [4:0] mapT,
  input  logic [4:0] mapB,
  output logic [9:0] redghostX,
  output logic [9:0] redghostY,
  output logic [9:0] redghostS
);

  typedef enum logic {IDLE, CHASE} state_t;

  localparam logic [1:0] DIR_LEFT  = 2'd0;
  localparam logic [1:0] DIR_RIGHT = 2'd1;
  localparam logic [1:0] DIR_UP    = 2'd2;
  localparam logic [1:0] DIR_DOWN  = 2'd3;

  localparam logic [10:0] LO_X = {1'b0, X_MIN} + {1'b0, SIZE} + {1'b0, STEP};
  localparam logic [10:0] LO_Y = {1'b0, Y_MIN} + {1'b0, SIZE} + {1'b0, STEP};
  localparam logic [10:0] REACH = {1'b0, SIZE} + {1'b0, STEP};

  state_t     state, state_n;
  logic [1:0] dir, dir_n;
  logic [9:0] pos_x_n, pos_y_n;
  logic [3:0] lfsr;
  logic       frame_q;
  logic       tick;
  logic [3:0] blk;
  logic [10:0] x_wide, y_wide;
  logic [1:0] pick, cand;
  logic       found;

  assign redghostS = SIZE;
  assign tick      = frame_clk & ~frame_q;
  assign x_wide    = {1'b0, redghostX};
  assign y_wide    = {1'b0, redghostY};

  // Widened compares so the edge bounds never wrap near zero or the far limit.
  assign blk[DIR_LEFT]  = (mapL != 5'd0) || (x_wide < LO_X);
  assign blk[DIR_RIGHT] = (mapR != 5'd0) || (x_wide + REACH > {1'b0, X_MAX});
  assign blk[DIR_UP]    = (mapT != 5'd0) || (y_wide < LO_Y);
  assign blk[DIR_DOWN]  = (mapB != 5'd0) || (y_wide + REACH > {1'b0, Y_MAX});

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state     <= IDLE;
      dir       <= DIR_LEFT;
      redghostX <= START_X;
      redghostY <= START_Y;
      lfsr      <= 4'b1001;
      frame_q   <= 1'b0;
    end else begin
      state     <= state_n;
      dir       <= dir_n;
      redghostX <= pos_x_n;
      redghostY <= pos_y_n;
      lfsr      <= {lfsr[2:0], lfsr[3] ^ lfsr[2]};
      frame_q   <= frame_clk;
    end
  end

  // First open direction, scanning upward from a random start.
  always_comb begin
    pick  = dir;
    found = 1'b0;
    cand  = lfsr[1:0];
    for (int i = 0; i < 4; i++) begin
      cand = lfsr[1:0] + 2'(i);
      if (!found && !blk[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_n = state;
    dir_n   = dir;
    pos_x_n = redghostX;
    pos_y_n = redghostY;
    if (restart) begin
      state_n = IDLE;
      dir_n   = DIR_LEFT;
      pos_x_n = START_X;
      pos_y_n = START_Y;
    end else if (lifeDown) begin
      dir_n   = DIR_LEFT;
      pos_x_n = START_X;
      pos_y_n = START_Y;
    end else begin
      case (state)
        IDLE: begin
          if (keycode != 8'd0) state_n = CHASE;
        end
        CHASE: begin
          if (tick) begin
            if (!blk[dir]) begin
              case (dir)
                DIR_LEFT:  pos_x_n = redghostX - STEP;
                DIR_RIGHT: pos_x_n = redghostX + STEP;
                DIR_UP:    pos_y_n = redghostY - STEP;
                default:   pos_y_n = redghostY + STEP;
              endcase
            end else if (found) begin
              dir_n = pick;
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_red_ghost.sv
// Self-checking bench for red_ghost: a behavioural model predicts each frame's
// position into a scoreboard queue, a monitor compares after every tick edge.
module tb_red_ghost;

  logic       Clk = 1'b0;
  logic       Reset = 1'b0;
  logic       frame_clk = 1'b0;
  logic [7:0] keycode = 8'd0;
  logic       lifeDown = 1'b0;
  logic       restart = 1'b0;
  logic [4:0] mapL = 5'd0, mapR = 5'd0, mapT = 5'd0, mapB = 5'd0;
  logic [9:0] redghostX, redghostY, redghostS;

  int n_tests = 0;
  int n_fail  = 0;

  logic [19:0] exp_q[$];

  int         m_x = 320, m_y = 200;
  logic [1:0] m_dir = 2'd0;
  bit         m_chase = 1'b0;
  logic [3:0] m_lfsr;
  bit         fc_hist = 1'b0;

  red_ghost dut (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .keycode(keycode),
    .lifeDown(lifeDown), .restart(restart),
    .mapL(mapL), .mapR(mapR), .mapT(mapT), .mapB(mapB),
    .redghostX(redghostX), .redghostY(redghostY), .redghostS(redghostS)
  );

  always #5 Clk = ~Clk;

  // Free-running x^4+x^3+1 sequence, restarted only by Reset.
  always @(posedge Clk or negedge Reset) begin
    if (!Reset) m_lfsr <= 4'b1001;
    else        m_lfsr <= {m_lfsr[2:0], m_lfsr[3] ^ m_lfsr[2]};
  end

  // Scoreboard monitor: each frame_clk rise yields one registered result.
  always begin
    bit fire;
    logic [19:0] e;
    @(posedge Clk);
    fire = Reset && frame_clk && !fc_hist;
    fc_hist = Reset ? frame_clk : 1'b0;
    if (fire) begin
      #1;
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL scoreboard_underflow: got X=%0d Y=%0d, no expected entry", redghostX, redghostY);
      end else begin
        e = exp_q.pop_front();
        if ({redghostX, redghostY} !== e) begin
          n_fail++;
          $display("FAIL frame_pos: got X=%0d Y=%0d, want X=%0d Y=%0d",
                   redghostX, redghostY, e[19:10], e[9:0]);
        end
      end
    end
  end

  function automatic bit m_blk(input logic [1:0] d, input int x, input int y);
    case (d)
      2'd0:    return (mapL != 0) || (x < 0 + 6 + 1);
      2'd1:    return (mapR != 0) || (x + 6 + 1 > 639);
      2'd2:    return (mapT != 0) || (y < 0 + 6 + 1);
      default: return (mapB != 0) || (y + 6 + 1 > 479);
    endcase
  endfunction

  task automatic model_step();
    logic [1:0] c;
    if (!m_chase) return;
    if (!m_blk(m_dir, m_x, m_y)) begin
      case (m_dir)
        2'd0: m_x = m_x - 1;
        2'd1: m_x = m_x + 1;
        2'd2: m_y = m_y - 1;
        default: m_y = m_y + 1;
      endcase
    end else begin
      for (int i = 0; i < 4; i++) begin
        c = m_lfsr[1:0] + 2'(i);
        if (!m_blk(c, m_x, m_y)) begin
          m_dir = c;
          break;
        end
      end
    end
  endtask

  task automatic send_tick();
    @(negedge Clk);
    frame_clk = 1'b1;
    model_step();
    exp_q.push_back({10'(m_x), 10'(m_y)});
    @(negedge Clk);
    frame_clk = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b0;
    repeat (2) @(negedge Clk);
    n_tests++;
    if ({redghostX, redghostY, redghostS} !== {10'd320, 10'd200, 10'd6}) begin
      n_fail++;
      $display("FAIL reset_vals: got X=%0d Y=%0d S=%0d, want 320 200 6", redghostX, redghostY, redghostS);
    end
    Reset = 1'b1;
    for (int i = 0; i < 10; i++) send_tick();
    n_tests++;
    if (redghostS !== 10'd6) begin
      n_fail++;
      $display("FAIL size_const: got %0d, want 6", redghostS);
    end
  endtask

  task automatic test_chase();
    @(negedge Clk);
    keycode = 8'h1A;
    @(negedge Clk);
    m_chase = 1'b1;
    for (int i = 0; i < 5; i++) send_tick();
    n_tests++;
    if (redghostX !== 10'd315 || redghostY !== 10'd200) begin
      n_fail++;
      $display("FAIL chase_5: got X=%0d Y=%0d, want 315 200", redghostX, redghostY);
    end
  endtask

  task automatic test_hold_high();
    @(negedge Clk);
    frame_clk = 1'b1;
    model_step();
    exp_q.push_back({10'(m_x), 10'(m_y)});
    repeat (5) @(negedge Clk);
    frame_clk = 1'b0;
    n_tests++;
    if (redghostX !== 10'd314 || redghostY !== 10'd200) begin
      n_fail++;
      $display("FAIL held_frame: got X=%0d Y=%0d, want 314 200", redghostX, redghostY);
    end
  endtask

  task automatic test_wall();
    int x0, y0;
    x0 = m_x; y0 = m_y;
    mapL = 5'b00100;
    send_tick();
    mapL = 5'd0;
    n_tests++;
    if (redghostX !== 10'(x0) || redghostY !== 10'(y0)) begin
      n_fail++;
      $display("FAIL wall_hold: got X=%0d Y=%0d, want %0d %0d", redghostX, redghostY, x0, y0);
    end
    send_tick();
    n_tests++;
    if (m_dir == 2'd0 || {redghostX, redghostY} === {10'(x0), 10'(y0)}) begin
      n_fail++;
      $display("FAIL wall_turn: got X=%0d Y=%0d, want a move away from left (dir %0d)", redghostX, redghostY, m_dir);
    end
  endtask

  task automatic test_min_bound();
    int guard;
    @(negedge Clk);
    lifeDown = 1'b1;
    @(negedge Clk);
    lifeDown = 1'b0;
    m_x = 320; m_y = 200; m_dir = 2'd0;
    n_tests++;
    if (redghostX !== 10'd320 || redghostY !== 10'd200) begin
      n_fail++;
      $display("FAIL life_respawn: got X=%0d Y=%0d, want 320 200", redghostX, redghostY);
    end
    guard = 0;
    while (m_x != 7 && guard < 400) begin
      send_tick();
      guard++;
    end
    n_tests++;
    if (redghostX !== 10'd7) begin
      n_fail++;
      $display("FAIL reach_x7: got X=%0d, want 7", redghostX);
    end
    for (int i = 0; i < 20; i++) begin
      send_tick();
      n_tests++;
      if (redghostX < 10'd6) begin
        n_fail++;
        $display("FAIL x_min_bound: got X=%0d, want >= 6", redghostX);
      end
    end
  endtask

  task automatic test_restart();
    for (int i = 0; i < 30; i++) send_tick();
    @(negedge Clk);
    restart = 1'b1;
    keycode = 8'd0;
    @(negedge Clk);
    restart = 1'b0;
    m_x = 320; m_y = 200; m_dir = 2'd0; m_chase = 1'b0;
    n_tests++;
    if (redghostX !== 10'd320 || redghostY !== 10'd200) begin
      n_fail++;
      $display("FAIL restart_pos: got X=%0d Y=%0d, want 320 200", redghostX, redghostY);
    end
    for (int i = 0; i < 5; i++) send_tick();
    @(negedge Clk);
    keycode = 8'h05;
    @(negedge Clk);
    m_chase = 1'b1;
    send_tick();
    n_tests++;
    if (redghostX !== 10'd319 || redghostY !== 10'd200) begin
      n_fail++;
      $display("FAIL restart_resume: got X=%0d Y=%0d, want 319 200", redghostX, redghostY);
    end
  endtask

  task automatic test_lifedown_tick();
    for (int i = 0; i < 3; i++) send_tick();
    @(negedge Clk);
    lifeDown  = 1'b1;
    frame_clk = 1'b1;
    m_x = 320; m_y = 200; m_dir = 2'd0;
    exp_q.push_back({10'd320, 10'd200});
    @(negedge Clk);
    lifeDown  = 1'b0;
    frame_clk = 1'b0;
    n_tests++;
    if (redghostX !== 10'd320 || redghostY !== 10'd200) begin
      n_fail++;
      $display("FAIL life_tick: got X=%0d Y=%0d, want 320 200", redghostX, redghostY);
    end
    send_tick();
    n_tests++;
    if (redghostX !== 10'd319 || redghostY !== 10'd200) begin
      n_fail++;
      $display("FAIL life_resume: got X=%0d Y=%0d, want 319 200", redghostX, redghostY);
    end
  endtask

  initial begin
    test_reset();
    test_chase();
    test_hold_high();
    test_wall();
    test_min_bound();
    test_restart();
    test_lifedown_tick();
    repeat (3) @(negedge Clk);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_leftover: got %0d entries, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/red_ghost.md
Name: red_ghost

Overview:
- Autonomous red-ghost sprite controller for the Pac-Man game: holds ghost centre position and size, advances one step per video frame through the maze.
- Picks a new direction pseudo-randomly when the path ahead is blocked by a wall or the screen edge.
- Sits between the keyboard/game-state logic (keycode, lifeDown, restart) and the sprite renderer/collision logic (redghostX/Y/S).

Parameters:
- START_X, 10'd320, reset/respawn X centre
- START_Y, 10'd200, reset/respawn Y centre
- SIZE, 10'd6, ghost half-size driven on redghostS
- STEP, 10'd1, pixels moved per frame tick
- X_MIN, 10'd0 / X_MAX, 10'd639, horizontal screen limits
- Y_MIN, 10'd0 / Y_MAX, 10'd479, vertical screen limits

Ports:
- Clk  in  1  system clock; the only clock, all state changes on its rising edge
- Reset  in  1  asynchronous, active-low reset
- frame_clk  in  1  vertical-sync-rate signal; sampled as data, never used as a clock
- keycode  in  8  last keyboard code; nonzero = a key is pressed
- lifeDown  in  1  Pac-Man lost a life; respawn ghost
- restart  in  1  game restart; respawn ghost and wait for a key
- mapL  in  5  wall samples left of ghost; any bit set = left blocked
- mapR  in  5  wall samples right of ghost; any bit set = right blocked
- mapT  in  5  wall samples above ghost; any bit set = up blocked
- mapB  in  5  wall samples below ghost; any bit set = down blocked
- redghostX  out  10  ghost centre X
- redghostY  out  10  ghost centre Y
- redghostS  out  10  ghost half-size, constant SIZE

Behaviour:
- Reset (Reset=0, async):
  - redghostX=START_X, redghostY=START_Y.
  - state=IDLE, dir=LEFT.
  - LFSR=4'b1001.
  - frame_clk history register=0.
- redghostS is always SIZE, including during reset.
- Frame tick:
  - frame_clk registered each Clk.
  - tick=1 for exactly one Clk when the registered value is 0 and the current value is 1 (rising edge).
  - A frame_clk held constant produces no ticks.
- LFSR: 4-bit, taps x^4+x^3+1, advances every Clk cycle outside reset; never reaches zero.
- Direction encoding: 0=LEFT, 1=RIGHT, 2=UP, 3=DOWN.
- Blocked flags, combinational:
  - blkL = (mapL!=0) or (redghostX < X_MIN+SIZE+STEP)
  - blkR = (mapR!=0) or (redghostX + SIZE + STEP > X_MAX)
  - blkU = (mapT!=0) or (redghostY < Y_MIN+SIZE+STEP)
  - blkD = (mapB!=0) or (redghostY + SIZE + STEP > Y_MAX)
- Comparisons are done in 11-bit unsigned arithmetic so there is no wrap.
- States:
  - IDLE: position held. If keycode!=0 on any Clk, go to CHASE next cycle.
  - CHASE, on each tick:
    - If the current dir is unblocked, position moves STEP in dir; dir is unchanged.
    - If the current dir is blocked, position is unchanged. dir is replaced by the first unblocked direction scanning from LFSR[1:0] upward, modulo 4.
    - If all four are blocked, dir and position are unchanged.
    - The new direction is first used on the next tick.
- Positions never leave [X_MIN+SIZE, X_MAX-SIZE] × [Y_MIN+SIZE, Y_MAX-SIZE]; there is no wrap-around.
- restart=1 (synchronous, level, checked every Clk): position←START, dir←LEFT, state←IDLE.
- lifeDown=1 (synchronous, level): position←START, dir←LEFT; the current state is kept.
- Priority, highest first: Reset > restart > lifeDown > keycode start > tick movement.
  - restart and lifeDown together behave as restart.
  - A tick coinciding with restart or lifeDown is discarded.
- Outputs are registered; a move is visible the Clk after the tick.

Test Plan:
- Hold Reset=0 for 2 cycles, then Reset=1 with frame_clk toggling and keycode=0 → X=320, Y=200, S=6, unchanged after 10 frames.
- From IDLE, keycode=8'h1A, map inputs all 0, 5 frame ticks → X=315, Y=200.
- In CHASE moving left, set mapL=5'b00100 for one tick → X holds. Dir becomes the first of R/U/D from LFSR[1:0]; the next tick moves one pixel in that direction.
- Ghost at X=7 moving left with map inputs 0 → blocked by X_MIN bound, X never below 6 over 20 ticks.
- After 30 moves, pulse restart for 1 Clk → X=320, Y=200 next cycle. No movement on later ticks until keycode!=0.
- Pulse lifeDown during CHASE, simultaneously with a tick → X=320, Y=200 next cycle, tick ignored. Movement resumes on the following tick without a key.
